pipe_adder: RTL

//  Parametrised, pipelined two's-complement adder/subtractor. It is the

---
 rtl/pipe_adder_pkg.sv | 16 +
 rtl/adder_seg.sv | 31 +++
 rtl/pipe_adder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation modes and
// the full-adder cell equations used by every ripple segment.
package pipe_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic logic fa_sum(input logic a, input logic b, input logic ci);
    return a ^ b ^ ci;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic ci);
    return (a & b) | (ci & (a ^ b));
  endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple slice built from full-adder cells. cmsb is the
// carry into the slice's top bit, needed for signed overflow on the last slice.
module adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int k = 0; k < SEG; k++) begin
      s[k]   = fa_sum(a[k], b[k], c[k]);
      c[k+1] = fa_carry(a[k], b[k], c[k]);
    end
  end

  assign cout = c[SEG];
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit ripple segment per
// stage, carry and untouched operand bits registered between stages.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] X,
  output logic             Y,
  output logic             OVF
);

  localparam int STAGES = WIDTH / SEG;

  for (genvar i = 0; i < STAGES; i++) begin : stg
    // Operands still to be added shrink by SEG bits per stage; the partial sum grows.
    localparam int SRC_W = WIDTH - SEG * i;
    localparam int SUM_W = SEG * (i + 1);

    logic [SRC_W-1:0] src_a;
    logic [SRC_W-1:0] src_b;
    logic             src_cin;
    logic             src_vld;
    logic             rdy;
    logic             vld_p;
    logic             c_p;
    logic             cout;
    logic [SEG-1:0]   s;
    logic [SUM_W-1:0] sum_next;
    logic [SUM_W-1:0] sum_p;

    // Stage input: the ports for stage 0 (B inverted with carry-in 1 on subtract),
    // otherwise the previous stage's registers.
    if (i == 0) begin : g_src
      assign src_a    = A;
      assign src_b    = (SUB == MODE_ADD) ? B : ~B;
      assign src_cin  = (SUB == MODE_SUB);
      assign src_vld  = in_valid;
      assign sum_next = s;
    end else begin : g_src
      assign src_a    = stg[i-1].g_ops.a_p;
      assign src_b    = stg[i-1].g_ops.b_p;
      assign src_cin  = stg[i-1].c_p;
      assign src_vld  = stg[i-1].vld_p;
      assign sum_next = {s, stg[i-1].sum_p};
    end

    if (i < STAGES - 1) begin : g_ops
      logic [SRC_W-SEG-1:0] a_p;
      logic [SRC_W-SEG-1:0] b_p;
      logic                 unused_cmsb;

      adder_seg #(.SEG(SEG)) u_seg (
        .a    (src_a[SEG-1:0]),
        .b    (src_b[SEG-1:0]),
        .cin  (src_cin),
        .s    (s),
        .cout (cout),
        .cmsb (unused_cmsb)
      );

      // A stage may load whenever it is empty or its successor is loading too.
      assign rdy = !vld_p || stg[i+1].rdy;

      always_ff @(posedge clk) begin
        if (rdy) begin
          a_p <= src_a[SRC_W-1:SEG];
          b_p <= src_b[SRC_W-1:SEG];
        end
      end
    end else begin : g_last
      logic cmsb;
      logic ovf_p;

      adder_seg #(.SEG(SEG)) u_seg (
        .a    (src_a[SEG-1:0]),
        .b    (src_b[SEG-1:0]),
        .cin  (src_cin),
        .s    (s),
        .cout (cout),
        .cmsb (cmsb)
      );

      assign rdy = !vld_p || out_ready;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_p <= 1'b0;
        end else if (rdy) begin
          ovf_p <= cmsb ^ cout;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
      end else if (rdy) begin
        vld_p <= src_vld;
      end
    end

    // Only the output stage's data is cleared so X/Y start at zero.
    always_ff @(posedge clk) begin
      if (!rst_n && (i == STAGES - 1)) begin
        sum_p <= '0;
        c_p   <= 1'b0;
      end else if (rdy) begin
        sum_p <= sum_next;
        c_p   <= cout;
      end
    end
  end

  assign in_ready  = stg[0].rdy;
  assign out_valid = stg[STAGES-1].vld_p;
  assign X         = stg[STAGES-1].sum_p;
  assign Y         = stg[STAGES-1].c_p;
  assign OVF       = stg[STAGES-1].g_last.ovf_p;

endmodule
